// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit with a req/ack bus handshake,
// byte/half/word lane steering, load extension, pipeline stall and error flags.
`default_nettype none

module mem_stage_lsu #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              mem_valid,
  input  logic              mem_wen,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_done,
  output logic              mem_err,
  output logic              mem_stall,
  output logic              Bus_req,
  output logic              Bus_wen,
  output logic [ADDR_W-1:0] Bus_addr,
  output logic [3:0]        Bus_be,
  output logic [31:0]       Bus_wdata,
  input  logic [31:0]       Bus_rdata,
  input  logic              Bus_ack
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic                wen_q;
  logic [1:0]          size_q;
  logic                uns_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         rdata_q;
  logic                err_q;

  logic                bad_access;
  logic [3:0]          be_w;
  logic [31:0]         wdata_w;
  logic                in_req;

  // Reserved size is treated the same as a misaligned access.
  always_comb begin
    bad_access = 1'b0;
    case (mem_size)
      2'b00:   bad_access = 1'b0;
      2'b01:   bad_access = mem_addr[0];
      2'b10:   bad_access = |mem_addr[1:0];
      default: bad_access = 1'b1;
    endcase
  end

  function automatic logic [31:0] fmt_load(input logic [31:0] d, input logic [1:0] sz,
                                           input logic uns, input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = d[{lane, 3'b000} +: 8];
    h = lane[1] ? d[31:16] : d[15:0];
    case (sz)
      2'b00:   r = {{24{b[7] & ~uns}}, b};
      2'b01:   r = {{16{h[15] & ~uns}}, h};
      default: r = d;
    endcase
    return r;
  endfunction

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      wen_q   <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt     <= '0;
          rdata_q <= '0;
          err_q   <= 1'b0;
          if (mem_valid) begin
            if (bad_access) begin
              err_q <= 1'b1;
              state <= DONE;
            end else begin
              wen_q   <= mem_wen;
              size_q  <= mem_size;
              uns_q   <= mem_unsigned;
              addr_q  <= mem_addr;
              wdata_q <= mem_wdata;
              state   <= REQ;
            end
          end
        end
        REQ: begin
          if (Bus_ack) begin
            rdata_q <= wen_q ? 32'h0 : fmt_load(Bus_rdata, size_q, uns_q, addr_q[1:0]);
            state   <= DONE;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            // This is the TIMEOUT-th request cycle without an ack.
            err_q <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    be_w = 4'b0000;
    case (size_q)
      2'b00:   be_w = 4'b0001 << addr_q[1:0];
      2'b01:   be_w = addr_q[1] ? 4'b1100 : 4'b0011;
      default: be_w = 4'b1111;
    endcase
  end

  always_comb begin
    wdata_w = 32'h0;
    case (size_q)
      2'b00:   wdata_w = {4{wdata_q[7:0]}};
      2'b01:   wdata_w = {2{wdata_q[15:0]}};
      default: wdata_w = wdata_q;
    endcase
  end

  // Bus outputs are forced to zero outside a request so stale latched
  // values never appear on the bus.
  assign in_req    = (state == REQ);
  assign Bus_req   = in_req;
  assign Bus_wen   = in_req & wen_q;
  assign Bus_addr  = in_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign Bus_be    = in_req ? be_w : 4'b0000;
  assign Bus_wdata = in_req ? wdata_w : 32'h0;

  assign mem_done  = (state == DONE);
  assign mem_err   = mem_done & err_q;
  assign mem_rdata = (mem_done & ~err_q) ? rdata_q : 32'h0;
  assign mem_stall = mem_valid & (state != DONE);

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: table-driven and randomized checks of mem_stage_lsu
// against a behavioural bus/load model.
`default_nettype none

module tb_mem_stage_lsu;

  localparam int TMO = 4;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst = 1'b1;
  logic        mem_valid = 1'b0;
  logic        mem_wen = 1'b0;
  logic [1:0]  mem_size = 2'b00;
  logic        mem_unsigned = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        mem_err;
  logic        mem_stall;
  logic        Bus_req;
  logic        Bus_wen;
  logic [31:0] Bus_addr;
  logic [3:0]  Bus_be;
  logic [31:0] Bus_wdata;
  logic [31:0] Bus_rdata = 32'h0;
  logic        Bus_ack = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  mem_stage_lsu #(.ADDR_W(32), .TIMEOUT(TMO), .CNT_W(8)) dut (
    .cpu_clk      (cpu_clk),
    .cpu_rst      (cpu_rst),
    .mem_valid    (mem_valid),
    .mem_wen      (mem_wen),
    .mem_size     (mem_size),
    .mem_unsigned (mem_unsigned),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_done     (mem_done),
    .mem_err      (mem_err),
    .mem_stall    (mem_stall),
    .Bus_req      (Bus_req),
    .Bus_wen      (Bus_wen),
    .Bus_addr     (Bus_addr),
    .Bus_be       (Bus_be),
    .Bus_wdata    (Bus_wdata),
    .Bus_rdata    (Bus_rdata),
    .Bus_ack      (Bus_ack)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        wen;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] bus;
    int          delay;
    logic        err;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] bw;
    int          lat;
  } vec_t;

  // Reference model: values follow directly from the access rules.
  function automatic logic model_bad(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'b11) return 1'b1;
    if (size == 2'b01) return (addr % 2) != 0;
    if (size == 2'b10) return (addr % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] bus, input logic [1:0] size,
                                             input logic uns, input logic [31:0] addr);
    logic [31:0] v;
    int          lane;
    lane = int'(addr % 4);
    v = bus;
    if (size == 2'b00) begin
      v = (bus >> (8 * lane)) & 32'hFF;
      if (!uns && v >= 32'd128) v = v - 32'd256;
    end else if (size == 2'b01) begin
      v = (bus >> (8 * lane)) & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v - 32'd65536;
    end
    return v;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] size, input logic [31:0] addr);
    int lane;
    lane = int'(addr % 4);
    if (size == 2'b00) return 4'(1 << lane);
    if (size == 2'b01) return 4'(3 << lane);
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_bw(input logic [1:0] size, input logic [31:0] wd);
    if (size == 2'b00) return (wd & 32'hFF) * 32'h01010101;
    if (size == 2'b01) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  // Drives one access and acts as the bus slave; acks after `delay` waiting
  // request cycles. Expected latency counts cycles from first valid sample.
  task automatic run_txn(input vec_t v, input bit scramble, input string tag);
    int n;
    int reqs;
    bit fin;
    n = 0;
    reqs = 0;
    fin = 1'b0;
    @(negedge cpu_clk);
    mem_valid    = 1'b1;
    mem_wen      = v.wen;
    mem_size     = v.size;
    mem_unsigned = v.uns;
    mem_addr     = v.addr;
    mem_wdata    = v.wdata;
    #1;
    while (!fin && n < 20) begin
      chk({tag, " stall"}, 64'(mem_stall), 64'(n != v.lat));
      if (Bus_req) begin
        chk({tag, " bus_addr"}, 64'(Bus_addr), 64'(v.addr & 32'hFFFF_FFFC));
        chk({tag, " bus_be"}, 64'(Bus_be), 64'(v.be));
        chk({tag, " bus_wen"}, 64'(Bus_wen), 64'(v.wen));
        if (v.wen) chk({tag, " bus_wdata"}, 64'(Bus_wdata), 64'(v.bw));
        Bus_ack   = (reqs == v.delay);
        Bus_rdata = Bus_ack ? v.bus : $urandom;
        reqs++;
      end else begin
        Bus_ack   = 1'($urandom);
        Bus_rdata = $urandom;
      end
      if (mem_done) begin
        chk({tag, " latency"}, 64'(n), 64'(v.lat));
        chk({tag, " req_cycles"}, 64'(reqs), 64'(v.lat - 1));
        chk({tag, " err"}, 64'(mem_err), 64'(v.err));
        chk({tag, " rdata"}, 64'(mem_rdata), 64'(v.rdata));
        fin = 1'b1;
        mem_valid = 1'b0;
      end else begin
        @(negedge cpu_clk);
        #1;
        n++;
        if (scramble) begin
          mem_addr  = $urandom;
          mem_wdata = $urandom;
          mem_size  = 2'($urandom);
          mem_wen   = 1'($urandom);
        end
      end
    end
    if (!fin) begin
      chk({tag, " done_seen"}, 64'd0, 64'd1);
      mem_valid = 1'b0;
    end
  endtask

  vec_t tbl[13];
  vec_t rv;

  initial begin
    tbl[0]  = '{1'b0, 2'b10, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF, 0,  1'b0, 32'hDEADBEEF, 4'hF, 32'h0,        2};
    tbl[1]  = '{1'b0, 2'b00, 1'b0, 32'h103, 32'h0,        32'h80123456, 0,  1'b0, 32'hFFFFFF80, 4'h8, 32'h0,        2};
    tbl[2]  = '{1'b0, 2'b00, 1'b1, 32'h103, 32'h0,        32'h80123456, 1,  1'b0, 32'h00000080, 4'h8, 32'h0,        3};
    tbl[3]  = '{1'b1, 2'b01, 1'b0, 32'h202, 32'h1234ABCD, 32'hFFFFFFFF, 0,  1'b0, 32'h0,        4'hC, 32'hABCDABCD, 2};
    tbl[4]  = '{1'b0, 2'b10, 1'b0, 32'h101, 32'h0,        32'h0,        0,  1'b1, 32'h0,        4'h0, 32'h0,        1};
    tbl[5]  = '{1'b0, 2'b10, 1'b0, 32'h100, 32'h0,        32'h0,        99, 1'b1, 32'h0,        4'hF, 32'h0,        5};
    tbl[6]  = '{1'b0, 2'b01, 1'b0, 32'h102, 32'h0,        32'h80011234, 0,  1'b0, 32'hFFFF8001, 4'hC, 32'h0,        2};
    tbl[7]  = '{1'b0, 2'b01, 1'b1, 32'h100, 32'h0,        32'h1234F00D, 2,  1'b0, 32'h0000F00D, 4'h3, 32'h0,        4};
    tbl[8]  = '{1'b0, 2'b11, 1'b0, 32'h100, 32'h0,        32'h0,        0,  1'b1, 32'h0,        4'h0, 32'h0,        1};
    tbl[9]  = '{1'b1, 2'b00, 1'b0, 32'h101, 32'h000000AA, 32'h0,        0,  1'b0, 32'h0,        4'h2, 32'hAAAAAAAA, 2};
    tbl[10] = '{1'b1, 2'b10, 1'b0, 32'h010, 32'hCAFEF00D, 32'h0,        3,  1'b0, 32'h0,        4'hF, 32'hCAFEF00D, 5};
    tbl[11] = '{1'b0, 2'b00, 1'b0, 32'h102, 32'h0,        32'h007F0000, 0,  1'b0, 32'h0000007F, 4'h4, 32'h0,        2};
    tbl[12] = '{1'b0, 2'b01, 1'b0, 32'h103, 32'h0,        32'h0,        0,  1'b1, 32'h0,        4'h0, 32'h0,        1};

    repeat (3) @(negedge cpu_clk);
    #1;
    chk("reset outputs", {mem_rdata, mem_done, mem_err, mem_stall, Bus_req, Bus_wen, Bus_be},
        64'h0);
    chk("reset bus addr/wdata", {Bus_addr, Bus_wdata}, 64'h0);
    cpu_rst = 1'b0;

    for (int i = 0; i < 13; i++) run_txn(tbl[i], 1'b0, $sformatf("vec%0d", i));

    // Reset while a request is outstanding: bus drops, no completion.
    @(negedge cpu_clk);
    mem_valid = 1'b1; mem_wen = 1'b0; mem_size = 2'b10; mem_addr = 32'h300;
    Bus_ack = 1'b0;
    for (int k = 0; k < 5 && !Bus_req; k++) begin
      @(negedge cpu_clk);
      #1;
    end
    chk("rst: req before reset", 64'(Bus_req), 64'd1);
    cpu_rst = 1'b1;
    @(negedge cpu_clk);
    #1;
    chk("rst: req dropped", 64'(Bus_req), 64'd0);
    chk("rst: no done", 64'(mem_done), 64'd0);
    cpu_rst = 1'b0;
    mem_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge cpu_clk);
      #1;
      chk("rst: idle after", {mem_done, Bus_req}, 64'd0);
    end
    run_txn(tbl[5], 1'b0, "post-rst timeout");

    for (int i = 0; i < 40; i++) begin
      rv.wen   = 1'($urandom);
      rv.size  = 2'($urandom_range(0, 3));
      rv.uns   = 1'($urandom);
      rv.addr  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (rv.size == 2'b10) rv.addr = rv.addr & 32'hFFFF_FFFC;
        if (rv.size == 2'b01) rv.addr = rv.addr & 32'hFFFF_FFFE;
      end
      rv.wdata = $urandom;
      rv.bus   = $urandom;
      rv.delay = $urandom_range(0, TMO + 1);
      if (model_bad(rv.size, rv.addr)) begin
        rv.err = 1'b1;
        rv.lat = 1;
      end else if (rv.delay < TMO) begin
        rv.err = 1'b0;
        rv.lat = rv.delay + 2;
      end else begin
        rv.err = 1'b1;
        rv.lat = TMO + 1;
      end
      rv.rdata = (rv.err || rv.wen) ? 32'h0 : model_load(rv.bus, rv.size, rv.uns, rv.addr);
      rv.be    = model_be(rv.size, rv.addr);
      rv.bw    = model_bw(rv.size, rv.wdata);
      run_txn(rv, 1'b1, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
